polyq_fold_accumulate: RTL and testbench
========================================

Name: polyq_fold_accumulate

Overview:
- Downstream consumer of the polyQ clear stage.
- Once the Rq accumulator memory has been zeroed, this block takes a stream of (index, coefficient) product terms and accumulates each term into that memory modulo Q.
- Terms with index ≥ P are folded with x^P = x + 1, so a term at index k ≥ P is added at both k−P and k−P+1.
- Built as a read-modify-write pipeline against a dual-port memory, with forwarding so back-to-back hits on the same address accumulate correctly.

Parameters:
- P, 761, polynomial length; valid input indices are 0..2P−2.
- Q, 4591, coefficient modulus.
- AW, 11, memory address width.
- DW, 13, coefficient width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  term present on in_index/in_coef/in_last.
- in_ready  output  1  block can accept a term this cycle.
- in_index  input  AW  exponent k of the term, 0..2P−2.
- in_coef  input  DW  coefficient value, 0..8191.
- in_last  input  1  marks the final term of a batch.
- mem_rd_address  output  AW  registered read address to the accumulator memory.
- mem_rd_data  input  DW  memory read data, valid one cycle after mem_rd_address.
- mem_address_i  output  AW  registered write address.
- mem_input  output  DW  registered write data.
- write_enable  output  1  registered write strobe.
- busy  output  1  high while any accepted term has an outstanding write.
- done  output  1  one-cycle pulse on the cycle write_enable is high for the last write of an in_last term.
- index_err  output  1  sticky; set when an accepted in_index > 2P−2; cleared only by reset.

Behaviour:
- Reset:
  - All outputs are 0 except in_ready, which is 1 from the first cycle after reset.
  - The pipeline is emptied. Pending writes are discarded, so no write_enable occurs after reset.
  - index_err is cleared.
- Handshake:
  - A term is accepted on any edge with in_valid && in_ready.
  - Inputs need not be held after acceptance.
- Operand conditioning:
  - If in_coef ≥ Q, Q is subtracted once at acceptance.
- Fold FSM states: IDLE/ACCEPT and SECOND.
  - k < P: one RMW op at address k; in_ready stays 1.
  - P ≤ k ≤ 2P−2: op A at k−P is issued on the accept cycle. The FSM then enters SECOND, issues op B at k−P+1 with the same coefficient, and holds in_ready=0 for exactly that one cycle.
  - k > 2P−2: no memory op; index_err is set. If in_last is also set, done still pulses 3 cycles after acceptance.
- RMW pipeline:
  - Ops are issued at most one per cycle.
  - Issue cycle t: mem_rd_address is driven at t+1.
  - mem_rd_data is sampled at t+2.
  - sum = rd + coef; if sum ≥ Q then sum −= Q; width is DW+1 internally.
  - mem_address_i, mem_input and write_enable=1 are driven at t+3.
  - Latency from issue to write strobe is 3 cycles.
- Memory model:
  - Read-first memory: a read returns the old data if the write to that address is in the same cycle.
- Hazard forwarding:
  - When an op reaches the sum stage, the operand is taken from the youngest earlier op to the same address whose write is not yet visible to that op's read, instead of mem_rd_data.
  - This covers up to 2 in-flight predecessors. Result: any sequence of same-address terms accumulates exactly, with no stalls.
- Output timing:
  - write_enable is low on every cycle without a completing op; mem_input and mem_address_i are don't-care then.
  - done coincides with the write of op B for folded last terms, or op A for unfolded ones.
  - busy = any stage valid or FSM in SECOND.
- Reset mid-batch:
  - Any partially folded term is abandoned; only op A may already have been written.
  - Clearing the memory again is the clear stage's responsibility, not this block's.

Test Plan:
1. After reset (memory zeroed), send k=5 coef=100 then k=5 coef=200 back-to-back → writes at addr 5 of 100, then 300, on consecutive cycles 3 cycles after each accept.
2. k=10 coef=4590 twice, then coef=2 → addr 10 written 4590, then 4589, then 0 (mod-Q wrap checked each step).
3. k=761 coef=7 with in_last → in_ready low 1 cycle; addr 0 and addr 1 each written 7; done pulses with the addr-1 write.
4. k=1520 coef=9 then k=759 coef=1 back-to-back → addr 759 and addr 760 written 9, then addr 759 written 10 via forwarding.
5. in_coef=8191 at k=0 → addr 0 written 3600; k=1521 → no write, index_err=1 and it stays high.
6. Assert reset on the cycle after accepting k=800 → no write_enable afterwards; busy=0, in_ready=1, index_err=0 next cycle.

Source files
------------

// File: rtl/polyq_fold_accumulate_if.sv
// rtl/polyq_fold_accumulate_if.sv - term stream and accumulator memory bus for polyq_fold_accumulate
//
// Purpose: bundles the (index, coefficient) term handshake and the dual-port
// accumulator memory signals into one interface.
// Ports (slave = accumulator block, master = producer/memory side):
//   in_valid/in_ready        term handshake
//   in_index/in_coef/in_last term payload
//   mem_rd_address           registered read address (block -> memory)
//   mem_rd_data              read data, one cycle after the address (memory -> block)
//   mem_address_i/mem_input  registered write address/data (block -> memory)
//   write_enable             registered write strobe (block -> memory)
interface polyq_fold_accumulate_if #(
    parameter int AW = 11,
    parameter int DW = 13
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_index;
    logic [DW-1:0] in_coef;
    logic          in_last;
    logic [AW-1:0] mem_rd_address;
    logic [DW-1:0] mem_rd_data;
    logic [AW-1:0] mem_address_i;
    logic [DW-1:0] mem_input;
    logic          write_enable;

    modport slave (
        input  in_valid, in_index, in_coef, in_last, mem_rd_data,
        output in_ready, mem_rd_address, mem_address_i, mem_input, write_enable
    );

    modport master (
        output in_valid, in_index, in_coef, in_last, mem_rd_data,
        input  in_ready, mem_rd_address, mem_address_i, mem_input, write_enable
    );
endinterface

// File: rtl/polyq_fold_accumulate.sv
// rtl/polyq_fold_accumulate.sv - folding modulo-Q read-modify-write accumulator for polyQ products
//
// Purpose: accepts (index, coefficient) product terms and accumulates each
// into the Rq accumulator memory modulo Q. Indices k >= P are folded with
// x^P = x + 1, i.e. added at both k-P and k-P+1 over two consecutive cycles.
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   bus        polyq_fold_accumulate_if.slave (term stream + memory bus)
//   busy       any accepted term still has an outstanding write
//   done       pulses with the final write of an in_last term
//   index_err  sticky flag for an accepted index above 2P-2
module polyq_fold_accumulate #(
    parameter int P  = 761,
    parameter int Q  = 4591,
    parameter int AW = 11,
    parameter int DW = 13
) (
    input  logic                     clk,
    input  logic                     reset,
    polyq_fold_accumulate_if.slave   bus,
    output logic                     busy,
    output logic                     done,
    output logic                     index_err
);
    localparam logic [AW-1:0] P_A     = AW'(P);
    localparam logic [AW-1:0] MAX_IDX = AW'(2 * P - 2);
    localparam logic [DW-1:0] Q_D     = DW'(Q);
    localparam logic [DW:0]   Q_W     = (DW + 1)'(Q);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] b_addr_q, b_addr_d;
    logic [DW-1:0] b_coef_q, b_coef_d;
    logic          b_last_q, b_last_d;
    logic          err_q, err_d;

    // Op issued this cycle. iss_last without iss_wr is a bubble that only
    // carries a done pulse for a rejected last term.
    logic          iss_wr;
    logic          iss_last;
    logic [AW-1:0] iss_addr;
    logic [DW-1:0] iss_coef;
    logic [DW-1:0] coef_red;

    // Stage 1: read address presented to memory.
    logic          s1_wr_q, s1_last_q;
    logic [AW-1:0] s1_addr_q;
    logic [DW-1:0] s1_coef_q;
    // Stage 2: read data returns, sum formed.
    logic          s2_wr_q, s2_last_q;
    logic [AW-1:0] s2_addr_q;
    logic [DW-1:0] s2_coef_q;
    // Stage 3: write strobe to memory.
    logic          w_wr_q, w_last_q;
    logic [AW-1:0] w_addr_q;
    logic [DW-1:0] w_data_q;
    // Previous write: committed on the same edge as the stage-2 op's read,
    // which a read-first memory does not reflect.
    logic          pv_wr_q;
    logic [AW-1:0] pv_addr_q;
    logic [DW-1:0] pv_data_q;

    logic [DW-1:0] operand;
    logic [DW:0]   sum_raw;
    logic [DW:0]   sum_mod;

    // Inputs up to 8191 need at most one subtraction to land below Q.
    assign coef_red = (bus.in_coef >= Q_D) ? (bus.in_coef - Q_D) : bus.in_coef;

    // Fold FSM: next state and issue decode
    always_comb begin
        state_d  = state_q;
        b_addr_d = b_addr_q;
        b_coef_d = b_coef_q;
        b_last_d = b_last_q;
        err_d    = err_q;
        iss_wr   = 1'b0;
        iss_last = 1'b0;
        iss_addr = '0;
        iss_coef = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_index < P_A) begin
                        iss_wr   = 1'b1;
                        iss_addr = bus.in_index;
                        iss_coef = coef_red;
                        iss_last = bus.in_last;
                    end else if (bus.in_index <= MAX_IDX) begin
                        // Op A now; op B (one address up) next cycle carries the last flag.
                        iss_wr   = 1'b1;
                        iss_addr = bus.in_index - P_A;
                        iss_coef = coef_red;
                        b_addr_d = bus.in_index - P_A + AW'(1);
                        b_coef_d = coef_red;
                        b_last_d = bus.in_last;
                        state_d  = ST_SECOND;
                    end else begin
                        err_d    = 1'b1;
                        iss_last = bus.in_last;
                    end
                end
            end
            ST_SECOND: begin
                iss_wr   = 1'b1;
                iss_addr = b_addr_q;
                iss_coef = b_coef_q;
                iss_last = b_last_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Forwarding: the youngest older op to the same address wins.
    always_comb begin
        operand = bus.mem_rd_data;
        if (w_wr_q && (w_addr_q == s2_addr_q)) begin
            operand = w_data_q;
        end else if (pv_wr_q && (pv_addr_q == s2_addr_q)) begin
            operand = pv_data_q;
        end
        sum_raw = {1'b0, operand} + {1'b0, s2_coef_q};
        sum_mod = (sum_raw >= Q_W) ? (sum_raw - Q_W) : sum_raw;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            b_addr_q  <= '0;
            b_coef_q  <= '0;
            b_last_q  <= 1'b0;
            err_q     <= 1'b0;
            s1_wr_q   <= 1'b0;
            s1_last_q <= 1'b0;
            s1_addr_q <= '0;
            s1_coef_q <= '0;
            s2_wr_q   <= 1'b0;
            s2_last_q <= 1'b0;
            s2_addr_q <= '0;
            s2_coef_q <= '0;
            w_wr_q    <= 1'b0;
            w_last_q  <= 1'b0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
            pv_wr_q   <= 1'b0;
            pv_addr_q <= '0;
            pv_data_q <= '0;
        end else begin
            state_q   <= state_d;
            b_addr_q  <= b_addr_d;
            b_coef_q  <= b_coef_d;
            b_last_q  <= b_last_d;
            err_q     <= err_d;

            s1_wr_q   <= iss_wr;
            s1_last_q <= iss_last;
            if (iss_wr) begin
                s1_addr_q <= iss_addr;
                s1_coef_q <= iss_coef;
            end

            s2_wr_q   <= s1_wr_q;
            s2_last_q <= s1_last_q;
            s2_addr_q <= s1_addr_q;
            s2_coef_q <= s1_coef_q;

            w_wr_q    <= s2_wr_q;
            w_last_q  <= s2_last_q;
            w_addr_q  <= s2_addr_q;
            w_data_q  <= sum_mod[DW-1:0];

            pv_wr_q   <= w_wr_q;
            pv_addr_q <= w_addr_q;
            pv_data_q <= w_data_q;
        end
    end

    assign bus.in_ready       = (state_q == ST_IDLE);
    assign bus.mem_rd_address = s1_addr_q;
    assign bus.mem_address_i  = w_addr_q;
    assign bus.mem_input      = w_data_q;
    assign bus.write_enable   = w_wr_q;
    assign done               = w_last_q;
    assign index_err          = err_q;
    assign busy               = s1_wr_q | s1_last_q | s2_wr_q | s2_last_q |
                                w_wr_q | w_last_q | (state_q == ST_SECOND);
endmodule

// File: tb/tb_polyq_fold_accumulate.sv
// tb/tb_polyq_fold_accumulate.sv - self-checking bench for polyq_fold_accumulate
module tb_polyq_fold_accumulate;
    localparam int P  = 761;
    localparam int Q  = 4591;
    localparam int AW = 11;
    localparam int DW = 13;

    logic clk = 1'b0;
    logic reset;
    logic busy, done, index_err;

    polyq_fold_accumulate_if #(.AW(AW), .DW(DW)) bus ();

    polyq_fold_accumulate #(.P(P), .Q(Q), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .index_err (index_err)
    );

    always #5 clk = ~clk;

    // Read-first accumulator memory, zeroed by reset (stands in for the clear stage).
    logic [DW-1:0] mem_arr [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < (1 << AW); i++) mem_arr[i] <= '0;
            bus.mem_rd_data <= '0;
        end else begin
            bus.mem_rd_data <= mem_arr[bus.mem_rd_address];
            if (bus.write_enable) mem_arr[bus.mem_address_i] <= bus.mem_input;
        end
    end

    typedef struct {
        int cyc;
        bit wen;
        int addr;
        int data;
        bit dn;
    } exp_t;

    exp_t expq[$];
    int   ref_mem [0:P-1];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   exp_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock; outputs compared 1ns after the edge against the expected-write queue.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (expq.size() > 0 && expq[0].cyc == cyc) begin
            e = expq.pop_front();
            check("write_enable", bus.write_enable, e.wen);
            if (e.wen) begin
                check("write_addr", bus.mem_address_i, e.addr);
                check("write_data", bus.mem_input, e.data);
            end
            check("done", done, e.dn);
        end else begin
            check("idle_write_enable", bus.write_enable, 0);
            check("idle_done", done, 0);
        end
        check("index_err", index_err, exp_err);
    endtask

    function automatic int acc_add(input int a, input int c);
        ref_mem[a] = (ref_mem[a] + c) % Q;
        return ref_mem[a];
    endfunction

    // Reference: each term adds c*x^k; x^k for k >= P is x^(k-P) + x^(k-P+1).
    task automatic model(input int k, input int c, input bit last, input int acc);
        int cr;
        int v;
        cr = (c >= Q) ? c - Q : c;
        if (k < P) begin
            v = acc_add(k, cr);
            expq.push_back('{acc + 2, 1'b1, k, v, last});
        end else if (k <= 2 * P - 2) begin
            v = acc_add(k - P, cr);
            expq.push_back('{acc + 2, 1'b1, k - P, v, 1'b0});
            v = acc_add(k - P + 1, cr);
            expq.push_back('{acc + 3, 1'b1, k - P + 1, v, last});
        end else begin
            exp_err = 1'b1;
            if (last) expq.push_back('{acc + 2, 1'b0, 0, 0, 1'b1});
        end
    endtask

    task automatic send(input int k, input int c, input bit last, input bit track);
        int waitn;
        waitn = 0;
        bus.in_valid = 1'b1;
        bus.in_index = AW'(k);
        bus.in_coef  = DW'(c);
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && waitn < 8) begin
            tick();
            waitn++;
        end
        if (bus.in_ready !== 1'b1) begin
            check("accept_timeout", bus.in_ready, 1);
            bus.in_valid = 1'b0;
            return;
        end
        if (track) model(k, c, last, cyc + 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        check("drain_pending", expq.size(), 0);
        tick();
        check("busy_after_drain", busy, 0);
    endtask

    initial begin
        int r;
        int k;
        for (int i = 0; i < P; i++) ref_mem[i] = 0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_index = '0;
        bus.in_coef  = '0;
        bus.in_last  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_write_enable", bus.write_enable, 0);
        check("rst_rd_address", bus.mem_rd_address, 0);
        tick();
        check("post_rst_in_ready", bus.in_ready, 1);

        // Back-to-back hits on one address
        send(5, 100, 0, 1);
        send(5, 200, 0, 1);
        drain();

        // Modular wrap
        send(10, 4590, 0, 1);
        send(10, 4590, 0, 1);
        send(10, 2, 0, 1);
        drain();

        // Folded last term: one-cycle stall, done with the second write
        send(761, 7, 1, 1);
        check("fold_in_ready_low", bus.in_ready, 0);
        tick();
        check("fold_in_ready_back", bus.in_ready, 1);
        drain();

        // Folded term followed by a hit on its first address
        send(1520, 9, 0, 1);
        send(759, 1, 0, 1);
        drain();

        // Oversized coefficient, then out-of-range index (sticky error, done bubble)
        send(0, 8191, 0, 1);
        send(1521, 3, 1, 1);
        drain();
        check("index_err_sticky", index_err, 1);

        // Randomised terms concentrated on few addresses to stress forwarding
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      k = $urandom_range(0, 3);
            else if (r < 7) k = P + $urandom_range(0, 3);
            else if (r < 9) k = $urandom_range(0, 2 * P - 2);
            else            k = 2 * P - 1 + $urandom_range(0, 3);
            send(k, $urandom_range(0, 8191), ($urandom_range(0, 7) == 0), 1);
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();
        for (int a = 0; a < P; a++) check("mem_final", mem_arr[a], ref_mem[a]);

        // Reset right after accepting a folded term abandons it
        send(800, 5, 0, 0);
        reset   = 1'b1;
        exp_err = 1'b0;
        tick();
        reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_index_err", index_err, 0);
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
